// File: rtl/ir_decode.sv
// ir_decode: fetches one instruction word per request, holds it in IR and decodes its fields
module ir_decode #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic [15:0] pc_in,
  input  logic        flush,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [4:0]  imm5,
  output logic        extop,
  output logic        fetch_err,
  output logic [15:0] instr_count
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d, addr_q, addr_d, count_q, count_d;
  logic        req_q, req_d, valid_q, valid_d, err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (flush) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: if (fetch_en) begin
          state_d = WAIT;
          addr_d  = pc_in;
          req_d   = 1'b1;
          cnt_d   = 4'd0;
        end
        WAIT: if (imem_ready) begin
          state_d = HOLD;
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        HOLD: if (out_ready) begin
          // a new fetch can be issued in the same cycle the held word is accepted
          state_d = fetch_en ? WAIT : IDLE;
          count_d = count_q + 16'd1;
          valid_d = 1'b0;
          req_d   = fetch_en;
          addr_d  = fetch_en ? pc_in : addr_q;
          cnt_d   = 4'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
      addr_q  <= 16'h0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign out_valid   = valid_q;
  assign fetch_err   = err_q;
  assign instr_count = count_q;
  assign opcode      = ir_q[15:12];
  assign rd          = ir_q[11:9];
  assign rs1         = ir_q[8:6];
  assign rs2         = ir_q[5:3];
  assign imm5        = ir_q[4:0];
  assign extop       = !(ir_q[15:12] == 4'h1 || ir_q[15:12] == 4'h7);
endmodule
